// File: rtl/image_op_sequencer_pkg.sv
// Shared definitions for the frame point-operation sequencer: mode codes,
// controller state encoding, pixel layout and the saturating brightness helper.
package image_op_sequencer_pkg;

   localparam int BYTES_PER_PIX = 3;

   localparam logic [1:0] MODE_BRIGHT = 2'b00;
   localparam logic [1:0] MODE_INVERT = 2'b01;
   localparam logic [1:0] MODE_THRESH = 2'b10;
   localparam logic [1:0] MODE_GRAY   = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_RD_R  = 4'd1,
      S_RD_G  = 4'd2,
      S_RD_B  = 4'd3,
      S_CAP_B = 4'd4,
      S_WR_R  = 4'd5,
      S_WR_G  = 4'd6,
      S_WR_B  = 4'd7,
      S_DONE  = 4'd8
   } state_t;

   // Add or subtract a delta from one channel, clamping to [0, 255].
   function automatic logic [7:0] sat_bright(input logic [7:0] x,
                                              input logic       dn,
                                              input logic [7:0] v);
      logic [8:0] s;
      s = {1'b0, x} + {1'b0, v};
      if (dn) begin
         sat_bright = (x > v) ? (x - v) : 8'h00;
      end else begin
         sat_bright = s[8] ? 8'hFF : s[7:0];
      end
   endfunction

endpackage

// File: rtl/image_op_sequencer_pixel_point_op.sv
// Combinational point operation on one RGB pixel. Grayscale and threshold
// share a 10-bit channel sum so 255+255+255 cannot wrap.
module pixel_point_op
   import image_op_sequencer_pkg::*;
(
   input  logic [1:0] i_mode,
   input  logic       i_bright_dn,
   input  logic [7:0] i_value,
   input  logic [7:0] i_r,
   input  logic [7:0] i_g,
   input  logic [7:0] i_b,
   output logic [7:0] o_r,
   output logic [7:0] o_g,
   output logic [7:0] o_b
);

   logic [9:0] w_sum;
   logic [9:0] w_quot;
   logic [7:0] w_avg;
   logic [7:0] w_thr;

   assign w_sum  = {2'b00, i_r} + {2'b00, i_g} + {2'b00, i_b};
   assign w_quot = w_sum / 10'd3;
   assign w_avg  = w_quot[7:0];
   assign w_thr  = (w_avg > i_value) ? 8'hFF : 8'h00;

   // Select the result of the requested operation for all three channels.
   always_comb begin
      o_r = i_r;
      o_g = i_g;
      o_b = i_b;
      case (i_mode)
         MODE_BRIGHT: begin
            o_r = sat_bright(i_r, i_bright_dn, i_value);
            o_g = sat_bright(i_g, i_bright_dn, i_value);
            o_b = sat_bright(i_b, i_bright_dn, i_value);
         end
         MODE_INVERT: begin
            o_r = 8'hFF - i_r;
            o_g = 8'hFF - i_g;
            o_b = 8'hFF - i_b;
         end
         MODE_THRESH: begin
            o_r = w_thr;
            o_g = w_thr;
            o_b = w_thr;
         end
         default: begin
            o_r = w_avg;
            o_g = w_avg;
            o_b = w_avg;
         end
      endcase
   end

endmodule

// File: rtl/image_op_sequencer.sv
// Frame sequencer: for each pixel p, reads bytes 3p..3p+2 from a byte-wide
// single-port store, applies the latched point operation and writes the three
// results back in place. Seven cycles per pixel, one DONE cycle per pass.
//
// Memory handshake: mem_rd_en high in a cycle requests mem[mem_addr], which
// the store returns on mem_rdata in the next cycle; mem_wr_en high in a cycle
// writes mem_wdata to mem_addr at the end of that cycle. There is no
// back-pressure, and the two strobes are never high together.
module image_op_sequencer
   import image_op_sequencer_pkg::*;
#(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512,
   parameter int ADDR_W = 21
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic              bright_dn,
   input  logic [7:0]        value,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pix_count,
   output state_t            o_dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(BYTES_PER_PIX);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

   state_t            r_state;
   logic [1:0]        r_mode;
   logic              r_bright_dn;
   logic [7:0]        r_value;
   logic [ADDR_W-1:0] r_pix;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rd_en;
   logic              r_wr_en;
   logic              r_busy;
   logic              r_done;
   logic [7:0]        r_cap_r;
   logic [7:0]        r_cap_g;
   logic [7:0]        r_cap_b;

   logic [7:0]        w_op_r;
   logic [7:0]        w_op_g;
   logic [7:0]        w_op_b;
   logic [7:0]        w_wdata;

   // Operation runs only on captured channels and latched config, so the
   // write data cannot change during a strobe cycle.
   pixel_point_op u_op (
      .i_mode      (r_mode),
      .i_bright_dn (r_bright_dn),
      .i_value     (r_value),
      .i_r         (r_cap_r),
      .i_g         (r_cap_g),
      .i_b         (r_cap_b),
      .o_r         (w_op_r),
      .o_g         (w_op_g),
      .o_b         (w_op_b)
   );

   // Pick the channel result matching the current write state; zero otherwise.
   always_comb begin
      w_wdata = 8'h00;
      case (r_state)
         S_WR_R:  w_wdata = w_op_r;
         S_WR_G:  w_wdata = w_op_g;
         S_WR_B:  w_wdata = w_op_b;
         default: w_wdata = 8'h00;
      endcase
   end

   // Controller FSM; strobes and address are registered on entry to each state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mode      <= 2'b00;
         r_bright_dn <= 1'b0;
         r_value     <= 8'h00;
         r_pix       <= '0;
         r_base      <= '0;
         r_addr      <= '0;
         r_rd_en     <= 1'b0;
         r_wr_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cap_r     <= 8'h00;
         r_cap_g     <= 8'h00;
         r_cap_b     <= 8'h00;
      end else if (abort && (r_state != S_IDLE)) begin
         r_state <= S_IDLE;
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode      <= mode;
                  r_bright_dn <= bright_dn;
                  r_value     <= value;
                  r_pix       <= '0;
                  r_base      <= '0;
                  r_addr      <= '0;
                  r_rd_en     <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_RD_R;
               end
            end
            S_RD_R: begin
               r_addr  <= r_base + ONE;
               r_state <= S_RD_G;
            end
            S_RD_G: begin
               r_cap_r <= mem_rdata;
               r_addr  <= r_base + TWO;
               r_state <= S_RD_B;
            end
            S_RD_B: begin
               r_cap_g <= mem_rdata;
               r_rd_en <= 1'b0;
               r_state <= S_CAP_B;
            end
            S_CAP_B: begin
               r_cap_b <= mem_rdata;
               r_addr  <= r_base;
               r_wr_en <= 1'b1;
               r_state <= S_WR_R;
            end
            S_WR_R: begin
               r_addr  <= r_base + ONE;
               r_state <= S_WR_G;
            end
            S_WR_G: begin
               r_addr  <= r_base + TWO;
               r_state <= S_WR_B;
            end
            S_WR_B: begin
               r_wr_en <= 1'b0;
               if (r_pix == LAST_PIX) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_pix   <= r_pix + ONE;
                  r_base  <= r_base + PIX_STEP;
                  r_addr  <= r_base + PIX_STEP;
                  r_rd_en <= 1'b1;
                  r_state <= S_RD_R;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_rd_en <= 1'b0;
               r_wr_en <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_addr    = r_addr;
   assign mem_rd_en   = r_rd_en;
   assign mem_wr_en   = r_wr_en;
   assign mem_wdata   = w_wdata;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pix_count   = r_pix;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_image_op_sequencer.sv
// Bench for image_op_sequencer on a 4x2 frame with a behavioural byte store.
module tb_image_op_sequencer;
   import image_op_sequencer_pkg::*;

   localparam int WIDTH  = 4;
   localparam int HEIGHT = 2;
   localparam int ADDR_W = 5;
   localparam int NPIX   = WIDTH * HEIGHT;
   localparam int NBYTES = NPIX * 3;
   localparam int PASS_CYCLES = 7 * NPIX + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic              bright_dn = 1'b0;
   logic [7:0]        value = 8'h00;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [7:0]        mem_rdata = 8'h00;
   logic              mem_wr_en;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] pix_count;
   state_t            dbg_state;

   logic [7:0] mem [NBYTES];
   logic [7:0] img [NBYTES];
   logic       ld_req = 1'b0;

   int checks = 0;
   int failures = 0;

   // results of the last run_pass
   int done_cyc, busy_bad, overlap, late_strobes, pix_at_done;
   logic [2:0] post_done;

   typedef struct {
      logic [1:0] m;
      logic       dn;
      logic [7:0] v;
      logic [7:0] r, g, b;
      logic [7:0] er, eg, eb;
   } vec_t;
   vec_t tbl [7];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   image_op_sequencer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .bright_dn(bright_dn), .value(value), .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .pix_count(pix_count),
      .o_dbg_state(dbg_state)
   );

   // ---------------- behavioural frame store ----------------
   always @(posedge clk) begin
      if (ld_req) begin
         for (int i = 0; i < NBYTES; i++) mem[i] <= img[i];
      end else if (mem_wr_en && (int'(mem_addr) < NBYTES)) begin
         mem[mem_addr] <= mem_wdata;
      end
      if (mem_rd_en) mem_rdata <= (int'(mem_addr) < NBYTES) ? mem[mem_addr] : 8'h00;
   end

   // ---------------- reference model ----------------
   function automatic logic [23:0] model_pix(input logic [1:0] m, input logic dn,
                                             input int v, input int r, input int g, input int b);
      int ch [3];
      int o [3];
      int avg;
      ch[0] = r; ch[1] = g; ch[2] = b;
      avg = (r + g + b) / 3;
      for (int i = 0; i < 3; i++) begin
         case (m)
            2'd0:    o[i] = dn ? ((ch[i] < v) ? 0 : ch[i] - v) : ((ch[i] + v > 255) ? 255 : ch[i] + v);
            2'd1:    o[i] = 255 - ch[i];
            2'd2:    o[i] = (avg > v) ? 255 : 0;
            default: o[i] = avg;
         endcase
      end
      return {8'(o[0]), 8'(o[1]), 8'(o[2])};
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_frame();
      ld_req = 1'b1;
      @(posedge clk); #1;
      ld_req = 1'b0;
   endtask

   function automatic logic [23:0] mem_pix(input int p);
      return {mem[3*p], mem[3*p+1], mem[3*p+2]};
   endfunction

   function automatic logic [23:0] img_pix(input int p);
      return {img[3*p], img[3*p+1], img[3*p+2]};
   endfunction

   // Pulse start with the given config, then scramble the config inputs.
   // Cycle c=1 is the cycle right after the start cycle.
   task automatic run_pass(input logic [1:0] m, input logic dn, input logic [7:0] v,
                           input int abort_cyc, input int glitch_cyc);
      int limit;
      done_cyc = 0; busy_bad = 0; overlap = 0; late_strobes = 0; pix_at_done = -1;
      post_done = 3'b111;
      mode = m; bright_dn = dn; value = v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode = ~m; bright_dn = ~dn; value = ~v;
      limit = (abort_cyc > 0) ? abort_cyc + 12 : 200;
      for (int c = 1; c <= limit; c++) begin
         if (mem_rd_en && mem_wr_en) overlap++;
         if (abort_cyc > 0 && c > abort_cyc && (mem_rd_en || mem_wr_en || busy)) late_strobes++;
         if (done) begin
            done_cyc = c;
            pix_at_done = int'(pix_count);
            break;
         end
         if (!busy && !(abort_cyc > 0 && c > abort_cyc)) busy_bad++;
         abort = (c == abort_cyc);
         start = (c == glitch_cyc);
         @(posedge clk); #1;
      end
      abort = 1'b0;
      start = 1'b0;
      if (done_cyc > 0) begin
         @(posedge clk); #1;
         post_done = {busy, done, dbg_state != S_IDLE};
      end
   endtask

   task automatic check_pass(input string tag);
      check({tag, "_done_cycle"}, done_cyc, PASS_CYCLES);
      check({tag, "_busy_drop"}, busy_bad, 0);
      check({tag, "_rd_wr_overlap"}, overlap, 0);
      check({tag, "_pix_at_done"}, pix_at_done, NPIX - 1);
      check({tag, "_after_done"}, {29'd0, post_done}, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      tbl[0] = '{2'd1, 1'b0, 8'd0,   8'd10,  8'd20,  8'd30,  8'd245, 8'd235, 8'd225};
      tbl[1] = '{2'd0, 1'b0, 8'd100, 8'd200, 8'd50,  8'd0,   8'd255, 8'd150, 8'd100};
      tbl[2] = '{2'd0, 1'b1, 8'd100, 8'd200, 8'd50,  8'd0,   8'd100, 8'd0,   8'd0};
      tbl[3] = '{2'd3, 1'b0, 8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      tbl[4] = '{2'd3, 1'b0, 8'd0,   8'd1,   8'd1,   8'd2,   8'd1,   8'd1,   8'd1};
      tbl[5] = '{2'd2, 1'b0, 8'd128, 8'd130, 8'd130, 8'd130, 8'd255, 8'd255, 8'd255};
      tbl[6] = '{2'd2, 1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd0,   8'd0,   8'd0};

      // reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {mem_addr, mem_wdata, pix_count, mem_rd_en, mem_wr_en, busy, done},
            32'd0);
      check("reset_state", dbg_state, S_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed vectors: every pixel of the frame holds the table pixel
      for (int i = 0; i < 7; i++) begin
         for (int p = 0; p < NPIX; p++) begin
            img[3*p] = tbl[i].r; img[3*p+1] = tbl[i].g; img[3*p+2] = tbl[i].b;
         end
         load_frame();
         run_pass(tbl[i].m, tbl[i].dn, tbl[i].v, 0, 0);
         check_pass($sformatf("vec%0d", i));
         for (int p = 0; p < NPIX; p++)
            check($sformatf("vec%0d_pix%0d", i, p), mem_pix(p), {tbl[i].er, tbl[i].eg, tbl[i].eb});
      end

      // randomized frames against the reference model
      for (int k = 0; k < 8; k++) begin
         logic [1:0] rm;
         logic       rdn;
         logic [7:0] rv;
         rm  = 2'($urandom_range(0, 3));
         rdn = 1'($urandom_range(0, 1));
         rv  = 8'($urandom_range(0, 255));
         for (int j = 0; j < NBYTES; j++) begin
            case ($urandom_range(0, 5))
               0:       img[j] = 8'h00;
               1:       img[j] = 8'hFF;
               default: img[j] = 8'($urandom_range(0, 255));
            endcase
         end
         load_frame();
         run_pass(rm, rdn, rv, 0, 0);
         check_pass($sformatf("rnd%0d", k));
         for (int p = 0; p < NPIX; p++)
            check($sformatf("rnd%0d_m%0d_pix%0d", k, rm, p), mem_pix(p),
                  model_pix(rm, rdn, rv, img[3*p], img[3*p+1], img[3*p+2]));
      end

      // abort during WR_G of pixel 3 (cycle 1 + 7*3 + 5 = 27)
      for (int j = 0; j < NBYTES; j++) img[j] = 8'($urandom_range(0, 255));
      load_frame();
      run_pass(MODE_INVERT, 1'b0, 8'd0, 27, 0);
      check("abort_no_done", done_cyc, 0);
      check("abort_no_late_strobes", late_strobes, 0);
      check("abort_busy_before", busy_bad, 0);
      check("abort_state_idle", dbg_state, S_IDLE);
      for (int p = 0; p < NPIX; p++) begin
         logic [23:0] e;
         logic [23:0] o;
         o = img_pix(p);
         e = model_pix(MODE_INVERT, 1'b0, 0, img[3*p], img[3*p+1], img[3*p+2]);
         if (p == 3) e = {e[23:8], o[7:0]};
         else if (p > 3) e = o;
         check($sformatf("abort_pix%0d", p), mem_pix(p), e);
      end

      // asynchronous reset in the middle of a pass
      for (int j = 0; j < NBYTES; j++) img[j] = 8'($urandom_range(0, 255));
      load_frame();
      mode = MODE_GRAY; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midpass_reset_outputs",
            {mem_addr, mem_wdata, pix_count, mem_rd_en, mem_wr_en, busy, done}, 32'd0);
      check("midpass_reset_state", dbg_state, S_IDLE);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fresh pass with a start pulse and changed mode injected mid-pass
      for (int j = 0; j < NBYTES; j++) img[j] = 8'($urandom_range(0, 255));
      load_frame();
      run_pass(MODE_INVERT, 1'b0, 8'd0, 0, 20);
      check_pass("restart_glitch");
      for (int p = 0; p < NPIX; p++)
         check($sformatf("restart_pix%0d", p), mem_pix(p),
               model_pix(MODE_INVERT, 1'b0, 0, img[3*p], img[3*p+1], img[3*p+2]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
